// File: rtl/accumulator_sequencer.sv
// Sequences one run of the shared accumulator: clear, forward `count` operands, drain, capture, pulse done.
// Optional stall performance counter is built only when ACC_SEQ_STALL_CNT_EN is defined.
module accumulator_sequencer #(
  parameter int ACC_WIDTH    = 64,
  parameter int ADD_WIDTH    = 64,
  parameter int CNT_WIDTH    = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic                 abort,
  output logic                 busy,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [ADD_WIDTH-1:0] s_data,
  output logic                 acc_clear,
  output logic                 acc_en,
  output logic [ADD_WIDTH-1:0] acc_add,
  input  logic [ACC_WIDTH-1:0] acc_data,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] remaining,
  output logic [31:0]          stall_cycles
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   busy_q;
  logic                   s_ready_q;
  logic                   acc_clear_q;
  logic                   done_q;
  logic [ACC_WIDTH-1:0]   result_q;
  logic [CNT_WIDTH-1:0]   remaining_q;
  logic [DW-1:0]          drain_q;
  logic                   beat_d;
  logic [CNT_WIDTH-1:0]   remaining_d;

  // s_ready is a registered state flag, so a beat never loops back through s_valid.
  assign beat_d      = s_valid & s_ready_q;
  assign remaining_d = beat_d ? remaining_q - CNT_WIDTH'(1) : remaining_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      remaining_q <= '0;
      drain_q     <= '0;
    end else begin
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_CLEAR;
            busy_q      <= 1'b1;
            acc_clear_q <= 1'b1;
            remaining_q <= count;
          end
        end
        S_CLEAR: begin
          if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            remaining_q <= '0;
          end else if (remaining_q != '0) begin
            state_q   <= S_RUN;
            s_ready_q <= 1'b1;
          end else begin
            state_q <= S_DRAIN;
            drain_q <= DW'(DRAIN_CYCLES);
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            remaining_q <= '0;
          end else begin
            remaining_q <= remaining_d;
            if (beat_d && remaining_d == '0) begin
              state_q   <= S_DRAIN;
              s_ready_q <= 1'b0;
              drain_q   <= DW'(DRAIN_CYCLES);
            end
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            remaining_q <= '0;
            drain_q     <= '0;
          end else begin
            drain_q <= drain_q - DW'(1);
            if (drain_q == DW'(1)) begin
              result_q <= acc_data;
              state_q  <= S_DONE;
              done_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign s_ready   = s_ready_q;
  assign acc_clear = acc_clear_q;
  assign done      = done_q;
  assign result    = result_q;
  assign remaining = remaining_q;
  assign acc_en    = beat_d;
  assign acc_add   = beat_d ? s_data : '0;

`ifdef ACC_SEQ_STALL_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] stall_d;

  // Restarts on each accepted start; otherwise holds across done/abort and saturates.
  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == S_RUN && !s_valid && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed plus randomized bench for accumulator_sequencer with a transaction-level expectation model.
module tb_accumulator_sequencer;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] count;
  logic        abort;
  logic        busy;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic        acc_clear;
  logic        acc_en;
  logic [63:0] acc_add;
  logic [63:0] acc_data;
  logic [63:0] result;
  logic        done;
  logic [15:0] remaining;
  logic [31:0] stall_cycles;

  int tests = 0;
  int fails = 0;
  logic [63:0] ops[$];
  logic [63:0] last_result = '0;

  accumulator_sequencer #(
    .ACC_WIDTH(64), .ADD_WIDTH(64), .CNT_WIDTH(16), .DRAIN_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .acc_clear(acc_clear), .acc_en(acc_en), .acc_add(acc_add), .acc_data(acc_data),
    .result(result), .done(done), .remaining(remaining), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Accumulator environment: running sum fed by the sequencer.
  always @(posedge clk) begin
    if (acc_clear) acc_data <= '0;
    else if (acc_en) acc_data <= acc_data + acc_add;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_stall(input int stalls);
`ifdef ACC_SEQ_STALL_CNT_EN
    return 32'(stalls);
`else
    return 32'd0;
`endif
  endfunction

  // One full run: operands come from ops; valid is random or follows pat bit-by-cycle.
  task automatic run_op(input int n, input bit rnd, input logic [31:0] pat, input bit poke);
    logic [63:0] sum = '0;
    int stalls = 0;
    int beats = 0;
    int k = 0;
    start = 1'b1; count = 16'(n);
    tick();
    start = 1'b0; count = 16'($urandom);
    chk("clear_pulse", acc_clear, 1);
    chk("clear_busy", busy, 1);
    chk("clear_rdy", s_ready, 0);
    chk("clear_rem", remaining, 64'(n));
    tick();
    while (beats < n && k < 200) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : pat[k % 32];
      s_data  = ops[beats];
      if (poke) start = 1'b1;
      #1;
      chk("run_rdy", s_ready, 1);
      chk("run_rem", remaining, 64'(n - beats));
      chk("run_en", acc_en, s_valid);
      chk("run_add", acc_add, s_valid ? s_data : 64'd0);
      chk("run_done", done, 0);
      if (s_valid) begin
        sum += s_data;
        beats++;
      end else begin
        stalls++;
      end
      k++;
      tick();
    end
    s_valid = 1'b0;
    start = 1'b0;
    if (k >= 200) chk("run_bound", 64'(beats), 64'(n));
    for (int d = 0; d < D; d++) begin
      if (poke) start = 1'b1;
      #1;
      chk("drain_busy", busy, 1);
      chk("drain_rdy", s_ready, 0);
      chk("drain_en", acc_en, 0);
      chk("drain_done", done, 0);
      tick();
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_result", result, sum);
    chk("done_rem", remaining, 0);
    chk("done_stall", stall_cycles, 64'(exp_stall(stalls)));
    last_result = sum;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_result", result, sum);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; count = '0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rdy", s_ready, 0);
    chk("rst_clear", acc_clear, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_stall", stall_cycles, 0);
    tick();

    ops = '{64'd5, 64'd7, 64'd9};
    run_op(3, 1'b0, 32'hFFFF_FFFF, 1'b0);
    chk("plan_sum21", last_result, 64'd21);

    ops = '{};
    run_op(0, 1'b0, 32'hFFFF_FFFF, 1'b0);

    ops = '{64'd1, 64'd2, 64'd3, 64'd4};
    run_op(4, 1'b0, 32'h0000_0059, 1'b0);

    ops = '{64'hDEAD, 64'hBEEF};
    run_op(2, 1'b0, 32'hFFFF_FFFF, 1'b1);

    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(0, 8);
      ops = '{};
      for (int i = 0; i < n; i++) ops.push_back({$urandom, $urandom});
      run_op(n, 1'b1, 32'h0, 1'($urandom_range(0, 1)));
    end

    // Abort after two beats; the beat in the abort cycle is still forwarded.
    start = 1'b1; count = 16'd5;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 64'(i + 100);
      tick();
    end
    s_valid = 1'b1; s_data = 64'h55; abort = 1'b1;
    #1;
    chk("abort_beat_en", acc_en, 1);
    chk("abort_beat_add", acc_add, 64'h55);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rdy", s_ready, 0);
    chk("abort_rem", remaining, 0);
    chk("abort_result", result, last_result);
    chk("abort_stall", stall_cycles, 0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_nodone", done, 0);
      tick();
    end
    ops = '{64'h1234};
    run_op(1, 1'b0, 32'hFFFF_FFFF, 1'b0);

    // abort in IDLE is harmless
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    // Reset during DRAIN
    start = 1'b1; count = 16'd1;
    tick();
    start = 1'b0;
    tick();
    s_valid = 1'b1; s_data = 64'h77;
    tick();
    s_valid = 1'b0;
    chk("pre_rst_drain_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("drst_busy", busy, 0);
    chk("drst_rdy", s_ready, 0);
    chk("drst_clear", acc_clear, 0);
    chk("drst_en", acc_en, 0);
    chk("drst_done", done, 0);
    chk("drst_result", result, 0);
    chk("drst_rem", remaining, 0);
    chk("drst_stall", stall_cycles, 0);
    for (int i = 0; i < 5; i++) begin
      chk("drst_nodone", done, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/accumulator_sequencer.md
Name: accumulator_sequencer

Overview:
Controller that sequences one run of the shared wide accumulator datapath.
- On a start command it clears the accumulator.
- It then accepts exactly `count` operands over a valid/ready stream and forwards each one as a single add-enable beat.
- It waits a fixed drain latency, captures the accumulator value as the result, and pulses done.
- Sits between the operand source (IO/host logic) and the accumulator instance inside the top level.

Parameters:
- ACC_WIDTH, 64, width of the accumulator value and of result.
- ADD_WIDTH, 64, width of each operand and of acc_add.
- CNT_WIDTH, 16, width of count and remaining.
- DRAIN_CYCLES, 2, cycles between the last add beat and result capture; must be >= 1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  start command; sampled only in IDLE.
- count  input  CNT_WIDTH  number of operands for the run; sampled with start.
- abort  input  1  cancels the active run.
- busy  output  1  high in every state except IDLE.
- s_valid  input  1  operand valid.
- s_ready  output  1  operand ready.
- s_data  input  ADD_WIDTH  operand.
- acc_clear  output  1  clears the accumulator.
- acc_en  output  1  accumulator adds acc_add this cycle.
- acc_add  output  ADD_WIDTH  operand to the accumulator.
- acc_data  input  ACC_WIDTH  current accumulator value.
- result  output  ACC_WIDTH  captured result.
- done  output  1  one-cycle completion pulse.
- remaining  output  CNT_WIDTH  operands still to accept.
- stall_cycles  output  32  optional performance counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge), from any state, mid-run included:
  - state=IDLE.
  - busy, s_ready, acc_clear, acc_en, done all 0.
  - result=0, remaining=0, drain counter=0, stall_cycles=0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> CLEAR; latch remaining<=count.
  - start is ignored in all other states; no queuing.
- CLEAR:
  - acc_clear=1 for exactly this one cycle.
  - Next state is RUN if remaining!=0.
  - Otherwise (count==0) next state is DRAIN; the run then completes with result = cleared accumulator value (0).
- RUN:
  - s_ready=1. Output is registered from state only; it does not depend combinationally on s_valid.
  - A beat is a cycle with s_valid & s_ready.
  - On a beat: acc_en=1 and acc_add=s_data, both combinational in the same cycle; remaining decrements by 1.
  - Cycles with s_valid=0 are stalls: acc_en=0, nothing changes.
  - The beat that takes remaining from 1 to 0 moves to DRAIN and loads the drain counter with DRAIN_CYCLES.
- DRAIN:
  - s_ready=0, acc_en=0.
  - The drain counter decrements each cycle; DRAIN lasts exactly DRAIN_CYCLES cycles.
  - In the last DRAIN cycle, result<=acc_data; then go to DONE.
  - A count==0 run also spends DRAIN_CYCLES cycles here.
- DONE:
  - done=1 for one cycle, busy=1, then IDLE.
  - result holds until the next capture.
- acc_add is 0 whenever acc_en=0.
- abort=1 in CLEAR, RUN or DRAIN:
  - Next state is IDLE; no done pulse.
  - result is unchanged; remaining<=0.
  - A beat in the same cycle as abort is still forwarded (acc_en=1).
  - abort in IDLE or DONE has no effect; DONE still pulses.
- Latency: start accepted at cycle 0, no stalls, N operands -> done at cycle 2+N+DRAIN_CYCLES.
- remaining never underflows; CNT_WIDTH max count is allowed.

Optional Feature:
- Macro: ACC_SEQ_STALL_CNT_EN.
- Defined:
  - stall_cycles counts RUN cycles with s_valid=0.
  - Cleared on start acceptance; saturates at 2^32-1.
  - Holds its value after done or abort.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- DRAIN_CYCLES=2, start with count=3, s_valid=1 with data 5, 7, 9:
  - acc_clear at cycle 1; acc_en at cycles 2-4 carrying 5, 7, 9.
  - With acc_data modelled as a running sum, done at cycle 7 and result=21.
- count=0:
  - acc_clear at cycle 1, no acc_en, done at cycle 2+DRAIN_CYCLES, result=0.
- count=4 with s_valid toggling 1,0,0,1,1,0,1:
  - Exactly 4 acc_en beats, remaining goes 4→3→2→1→0.
  - With ACC_SEQ_STALL_CNT_EN, stall_cycles=3; without it, stall_cycles=0.
- abort mid-RUN after 2 of 5 beats:
  - Next cycle IDLE, busy=0, no done, result keeps its prior value.
  - A new start with count=1 then completes normally.
- start pulsed during RUN and DRAIN: ignored; only one done pulse occurs.
- rst=1 asserted in DRAIN: next cycle every output is at its reset value and no done pulse occurs.
